// File: rtl/rf_writeback_arbiter.sv
// Merges ALU and LSU results onto the single register-file write port.
// The LSU side is buffered in a small FIFO; RF_WB_FWD_EN adds a forwarding lookup.
module rf_writeback_arbiter #(
  parameter int addr_width = 5,
  parameter int XLEN       = 32,
  parameter int LSU_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [addr_width-1:0]         alu_addr,
  input  logic [XLEN-1:0]               alu_data,
  input  logic                          lsu_valid,
  output logic                          lsu_ready,
  input  logic [addr_width-1:0]         lsu_addr,
  input  logic [XLEN-1:0]               lsu_data,
  output logic                          rd_write_enable,
  output logic [addr_width-1:0]         rd_addr,
  output logic [XLEN-1:0]               rd_data_in,
  output logic [$clog2(LSU_DEPTH):0]    pending,
  input  logic [addr_width-1:0]         fwd_addr,
  output logic                          fwd_hit,
  output logic [XLEN-1:0]               fwd_data
);

  localparam int PW = $clog2(LSU_DEPTH);
  localparam int CW = PW + 1;

  logic [addr_width-1:0] fifo_addr [LSU_DEPTH];
  logic [XLEN-1:0]       fifo_data [LSU_DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;

  logic                  full;
  logic                  empty;
  logic                  sel_fifo;
  logic                  sel_alu;
  logic                  sel_byp;
  logic                  sel_any;
  logic                  pop;
  logic                  push;
  logic [addr_width-1:0] sel_addr;
  logic [XLEN-1:0]       sel_data;

  assign full  = (count == CW'(LSU_DEPTH));
  assign empty = (count == '0);

  // A full FIFO outranks the ALU so the LSU can always be accepted.
  assign sel_fifo = full || (!alu_valid && !empty);
  assign sel_alu  = !full && alu_valid;
  assign sel_byp  = empty && !alu_valid && lsu_valid;
  assign sel_any  = sel_fifo || sel_alu || sel_byp;

  assign pop       = !rst && sel_fifo;
  assign alu_ready = !rst && !full;
  assign lsu_ready = !rst && (!full || pop);
  assign push      = lsu_valid && lsu_ready && !sel_byp;

  assign sel_addr = sel_fifo ? fifo_addr[head] : (sel_alu ? alu_addr : lsu_addr);
  assign sel_data = sel_fifo ? fifo_data[head] : (sel_alu ? alu_data : lsu_data);

  assign pending = count;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[tail] <= lsu_addr;
      fifo_data[tail] <= lsu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Writes to x0 still use their slot; only the enable is suppressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_write_enable <= 1'b0;
      rd_addr         <= '0;
      rd_data_in      <= '0;
    end else begin
      rd_write_enable <= sel_any && (sel_addr != '0);
      if (sel_any) begin
        rd_addr    <= sel_addr;
        rd_data_in <= sel_data;
      end
    end
  end

`ifdef RF_WB_FWD_EN
  logic [PW-1:0] fwd_idx;

  // Scan oldest to youngest so the youngest matching entry overrides.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    if (fwd_addr != '0) begin
      if (rd_write_enable && (rd_addr == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = rd_data_in;
      end
      for (int i = 0; i < LSU_DEPTH; i++) begin
        fwd_idx = head + PW'(i);
        if ((CW'(i) < count) && (fifo_addr[fwd_idx] == fwd_addr)) begin
          fwd_hit  = 1'b1;
          fwd_data = fifo_data[fwd_idx];
        end
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^fwd_addr;
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter with hand-computed expectations.
module tb_rf_writeback_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        rd_write_enable;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data_in;
  logic [2:0]  pending;
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  int tests  = 0;
  int failed = 0;

  rf_writeback_arbiter #(.addr_width(5), .XLEN(32), .LSU_DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_addr        (alu_addr),
    .alu_data        (alu_data),
    .lsu_valid       (lsu_valid),
    .lsu_ready       (lsu_ready),
    .lsu_addr        (lsu_addr),
    .lsu_data        (lsu_data),
    .rd_write_enable (rd_write_enable),
    .rd_addr         (rd_addr),
    .rd_data_in      (rd_data_in),
    .pending         (pending),
    .fwd_addr        (fwd_addr),
    .fwd_hit         (fwd_hit),
    .fwd_data        (fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                     input logic lv, input logic [4:0] la, input logic [31:0] ld);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    lsu_valid = lv; lsu_addr = la; lsu_data = ld;
  endtask

  task automatic chk_out(input string tag, input logic we, input logic [4:0] a,
                         input logic [31:0] d, input logic [2:0] p);
    chk({tag, ".we"}, rd_write_enable, we);
    if (we) begin
      chk({tag, ".addr"}, rd_addr, a);
      chk({tag, ".data"}, rd_data_in, d);
    end
    chk({tag, ".pending"}, pending, p);
  endtask

  // Drive one cycle of inputs, check the readies, clock, then check the write port.
  task automatic step(input string tag,
                      input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic lv, input logic [4:0] la, input logic [31:0] ld,
                      input logic exp_ar, input logic exp_we, input logic [4:0] exp_a,
                      input logic [31:0] exp_d, input logic [2:0] exp_p);
    drv(av, aa, ad, lv, la, ld);
    #1;
    chk({tag, ".alu_ready"}, alu_ready, exp_ar);
    chk({tag, ".lsu_ready"}, lsu_ready, 1'b1);
    cyc();
    chk_out(tag, exp_we, exp_a, exp_d, exp_p);
  endtask

  initial begin
    rst = 1'b1;
    fwd_addr = '0;
    drv(0, 0, 0, 0, 0, 0);
    #1;
    chk("rst.we", rd_write_enable, 0);
    chk("rst.addr", rd_addr, 0);
    chk("rst.data", rd_data_in, 0);
    chk("rst.pending", pending, 0);
    chk("rst.alu_ready", alu_ready, 0);
    chk("rst.lsu_ready", lsu_ready, 0);
    cyc();
    rst = 1'b0;
    cyc();
    chk_out("idle0", 0, 0, 0, 0);

    // ALU only, then an idle cycle holds addr/data
    step("alu", 1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 1, 5, 32'hDEADBEEF, 0);
    drv(0, 0, 0, 0, 0, 0);
    cyc();
    chk("hold.we", rd_write_enable, 0);
    chk("hold.addr", rd_addr, 5);
    chk("hold.data", rd_data_in, 32'hDEADBEEF);

    // LSU bypass with empty FIFO
    step("byp", 0, 0, 0, 1, 7, 32'h12345678, 1, 1, 7, 32'h12345678, 0);

    // Destination x0 consumes the slot without a write
    step("x0", 1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 0, 0);

    // Contention: FIFO fills to 4, then full FIFO outranks the ALU
    step("ct0", 1, 1, 32'hA0, 1, 10, 32'hB0, 1, 1, 1, 32'hA0, 1);
    step("ct1", 1, 2, 32'hA1, 1, 11, 32'hB1, 1, 1, 2, 32'hA1, 2);
    step("ct2", 1, 3, 32'hA2, 1, 12, 32'hB2, 1, 1, 3, 32'hA2, 3);
    step("ct3", 1, 4, 32'hA3, 1, 13, 32'hB3, 1, 1, 4, 32'hA3, 4);
    step("ct4", 1, 5, 32'hA4, 1, 14, 32'hB4, 0, 1, 10, 32'hB0, 4);
    step("ct5", 1, 5, 32'hA4, 1, 15, 32'hB5, 0, 1, 11, 32'hB1, 4);
    step("ct6", 1, 5, 32'hA4, 0, 0, 0, 0, 1, 12, 32'hB2, 3);
    step("ct7", 1, 5, 32'hA4, 0, 0, 0, 1, 1, 5, 32'hA4, 3);
    step("ct8", 0, 0, 0, 0, 0, 0, 1, 1, 13, 32'hB3, 2);
    step("ct9", 0, 0, 0, 0, 0, 0, 1, 1, 14, 32'hB4, 1);
    step("ct10", 0, 0, 0, 0, 0, 0, 1, 1, 15, 32'hB5, 0);
    step("ct11", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    // Forwarding: FIFO holds reg 9 = 0xA (head) then 0xB (tail); output holds reg 2
    step("fw0", 1, 1, 32'h11, 1, 9, 32'hA, 1, 1, 1, 32'h11, 1);
    step("fw1", 1, 2, 32'h22, 1, 9, 32'hB, 1, 1, 2, 32'h22, 2);
    drv(0, 0, 0, 0, 0, 0);
    fwd_addr = 9;
    #1;
`ifdef RF_WB_FWD_EN
    chk("fwd9.hit", fwd_hit, 1);
    chk("fwd9.data", fwd_data, 32'hB);
    fwd_addr = 2;
    #1;
    chk("fwd2.hit", fwd_hit, 1);
    chk("fwd2.data", fwd_data, 32'h22);
    fwd_addr = 0;
    #1;
    chk("fwd0.hit", fwd_hit, 0);
`else
    chk("nofwd.hit", fwd_hit, 0);
    chk("nofwd.data", fwd_data, 0);
`endif
    fwd_addr = 0;
    cyc();
    chk_out("fwdrain0", 1, 9, 32'hA, 1);
    cyc();
    chk_out("fwdrain1", 1, 9, 32'hB, 0);

    // Reset with three buffered LSU results
    step("rs0", 1, 1, 32'h1, 1, 20, 32'h20, 1, 1, 1, 32'h1, 1);
    step("rs1", 1, 2, 32'h2, 1, 21, 32'h21, 1, 1, 2, 32'h2, 2);
    step("rs2", 1, 3, 32'h3, 1, 22, 32'h22, 1, 1, 3, 32'h3, 3);
    drv(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("rsm.we", rd_write_enable, 0);
    chk("rsm.addr", rd_addr, 0);
    chk("rsm.data", rd_data_in, 0);
    chk("rsm.pending", pending, 0);
    chk("rsm.alu_ready", alu_ready, 0);
    chk("rsm.lsu_ready", lsu_ready, 0);
    cyc();
    rst = 1'b0;
    cyc();
    chk_out("post_rst0", 0, 0, 0, 0);
    cyc();
    chk_out("post_rst1", 0, 0, 0, 0);
    step("post_rst2", 1, 6, 32'h66, 0, 0, 0, 1, 1, 6, 32'h66, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Write-side initiator for the register file's single write port.
- Merges results from the single-cycle ALU path and the variable-latency LSU path onto one registered write per cycle.
- LSU results are buffered in a small FIFO so the LSU never blocks on ALU traffic.
- Sits between execute/memory stages and the register file; its registered outputs connect directly to the rf write port fields.

Parameters:
- addr_width, 5, register index width
- XLEN, 32, data width
- LSU_DEPTH, 4, LSU result FIFO entries (power of two, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  ALU result accepted this cycle (combinational)
- alu_addr  in  addr_width  ALU destination register
- alu_data  in  XLEN  ALU result
- lsu_valid  in  1  LSU load result valid
- lsu_ready  out  1  LSU result accepted this cycle (combinational)
- lsu_addr  in  addr_width  LSU destination register
- lsu_data  in  XLEN  LSU load data
- rd_write_enable  out  1  to rf write port, registered
- rd_addr  out  addr_width  to rf write port, registered
- rd_data_in  out  XLEN  to rf write port, registered
- pending  out  $clog2(LSU_DEPTH)+1  FIFO occupancy, registered
- fwd_addr  in  addr_width  forwarding lookup index (RF_WB_FWD_EN only)
- fwd_hit  out  1  lookup matched an in-flight write (RF_WB_FWD_EN only)
- fwd_data  out  XLEN  forwarded data (RF_WB_FWD_EN only)

Behaviour:
- Clock and reset: one clock clk; rst is asynchronous and active-high.
- Reset: rd_write_enable=0, rd_addr=0, rd_data_in=0, FIFO emptied, pending=0. alu_ready=0 and lsu_ready=0 while rst is high.
- Handshake: a transfer occurs when valid&&ready in the same cycle. Producers hold addr/data stable while valid&&!ready.
- Selection each cycle (priority order):
  - (1) FIFO full: pop head to output; alu_ready=0.
  - (2) alu_valid: ALU to output; alu_ready=1.
  - (3) FIFO non-empty: pop head.
  - (4) FIFO empty and lsu_valid: LSU bypasses the FIFO straight to output.
  - (5) Otherwise: rd_write_enable=0 next cycle.
- alu_ready=1 whenever the FIFO is not full (and not in reset), regardless of alu_valid.
- lsu_ready=(count<LSU_DEPTH) || (pop this cycle). An accepted LSU result that is not bypassed is pushed at the FIFO tail.
- Simultaneous push and pop: occupancy unchanged. Push on full is legal only when a pop occurs in the same cycle.
- Latency:
  - ALU accept in cycle N -> rd_write_enable=1 in N+1.
  - LSU bypass -> N+1.
  - LSU buffered -> at least N+2.
- Output register loads the selected entry every cycle. With no selection, rd_write_enable=0; rd_addr and rd_data_in hold their previous values.
- Destination 0: accepted normally and consumes a write slot, but rd_write_enable stays 0 for that slot.
- FIFO pointers wrap modulo LSU_DEPTH. pending reflects occupancy after the clock edge.
- No ordering guarantee between ALU and LSU writes to the same register. Write-after-write hazards are the issue logic's responsibility.
- Reset mid-operation: all buffered and in-flight results are discarded, with no write on the cycle after reset deasserts.

Optional Feature:
- Macro RF_WB_FWD_EN.
- Defined:
  - fwd_hit/fwd_data compare fwd_addr combinationally against the output register (when rd_write_enable=1) and all valid FIFO entries.
  - The youngest match wins. Order, youngest first: FIFO tail ... FIFO head, then output register.
  - fwd_addr=0 never hits.
- Undefined: fwd_addr is unused; fwd_hit=0 and fwd_data=0 constantly; no comparators are synthesized.

Test Plan:
- ALU only: alu_valid=1, addr=5, data=0xDEADBEEF at cycle 3 -> alu_ready=1; cycle 4 rd_write_enable=1, rd_addr=5, rd_data_in=0xDEADBEEF.
- LSU bypass: FIFO empty, alu_valid=0, lsu addr=7, data=0x12345678 -> write of reg 7 next cycle; pending stays 0.
- Contention: ALU and LSU both valid for 6 cycles -> ALU writes first; LSU fills FIFO to 4; when full, alu_ready=0 and the head drains; every accepted result is written exactly once.
- Destination x0: alu_addr=0, data=0xFFFFFFFF -> alu_ready=1; rd_write_enable stays 0 in the following cycle.
- Reset mid-stream: rst asserted with pending=3 -> outputs and pending zero immediately; no writes after deassert until new input.
- With RF_WB_FWD_EN: FIFO holds reg 9 = 0xA then 0xB (0xB younger), fwd_addr=9 -> fwd_hit=1, fwd_data=0xB; fwd_addr=0 -> fwd_hit=0.
